// File: rtl/button_conditioner_pkg.sv
// Shared board timing constants and button FSM encoding for all push-button-driven display blocks.
package button_conditioner_pkg;

   localparam int CLK_HZ           = 100_000_000;
   localparam int DEBOUNCE_DEFAULT = 1_000_000;   // 10 ms
   localparam int LONG_DEFAULT     = 100_000_000; // 1 s
   localparam int REPEAT_DEFAULT   = 20_000_000;  // 200 ms

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HELD   = 2'd1,
      REPEAT = 2'd2
   } btn_state_e;

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit; 2-cycle latency, no flow control.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;

   always_comb begin
      s1_d = d;
      s2_d = s1_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/button_conditioner.sv
// Synchronise, debounce and classify a raw button into press/release/long/repeat pulses.
// level and flag rise DEBOUNCE_CYCLES+1 edges after btn is first sampled high; no backpressure.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int LONG_CYCLES     = LONG_DEFAULT,
   parameter int REPEAT_CYCLES   = REPEAT_DEFAULT,
   parameter int CNT_W           = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic flag,
   output logic release_flag,
   output logic long_flag,
   output logic repeat_flag
);

   localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   logic             btn_s;
   logic             level_q, level_d;
   logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   btn_state_e       state_q, state_d;
   logic             flag_q, flag_d;
   logic             release_flag_q, release_flag_d;
   logic             long_flag_q, long_flag_d;
   logic             repeat_flag_q, repeat_flag_d;
   logic             rise, fall;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn),
      .q   (btn_s)
   );

   // Debounce: any agreeing cycle restarts the stability window.
   always_comb begin
      level_d  = level_q;
      db_cnt_d = db_cnt_q;
      if (btn_s == level_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         level_d  = ~level_q;
         db_cnt_d = '0;
      end else begin
         db_cnt_d = db_cnt_q + 1'b1;
      end
      rise = level_d & ~level_q;
      fall = ~level_d & level_q;
   end

   // Flags are launched from the same edge that updates level, so they line up with it.
   always_comb begin
      state_d        = state_q;
      hold_d         = hold_q;
      flag_d         = 1'b0;
      release_flag_d = 1'b0;
      long_flag_d    = 1'b0;
      repeat_flag_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = HELD;
               hold_d  = '0;
               flag_d  = 1'b1;
            end
         end
         HELD: begin
            if (fall) begin
               state_d        = IDLE;
               hold_d         = '0;
               release_flag_d = 1'b1;
            end else if (hold_q == LONG_LAST) begin
               state_d     = REPEAT;
               hold_d      = '0;
               long_flag_d = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         REPEAT: begin
            if (fall) begin
               state_d        = IDLE;
               hold_d         = '0;
               release_flag_d = 1'b1;
            end else if (hold_q == REPEAT_LAST) begin
               hold_d        = '0;
               repeat_flag_d = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            hold_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q        <= 1'b0;
         db_cnt_q       <= '0;
         hold_q         <= '0;
         state_q        <= IDLE;
         flag_q         <= 1'b0;
         release_flag_q <= 1'b0;
         long_flag_q    <= 1'b0;
         repeat_flag_q  <= 1'b0;
      end else begin
         level_q        <= level_d;
         db_cnt_q       <= db_cnt_d;
         hold_q         <= hold_d;
         state_q        <= state_d;
         flag_q         <= flag_d;
         release_flag_q <= release_flag_d;
         long_flag_q    <= long_flag_d;
         repeat_flag_q  <= repeat_flag_d;
      end
   end

   assign level        = level_q;
   assign flag         = flag_q;
   assign release_flag = release_flag_q;
   assign long_flag    = long_flag_q;
   assign repeat_flag  = repeat_flag_q;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage for every push-button-driven display block (scrolling text, counters, menus) on the 100 MHz board clock.
- Synchronises a raw mechanical button and debounces it into a clean level.
- Emits single-cycle event pulses: press, release, long-press and auto-repeat.
- `flag` is the drop-in one-cycle press pulse that downstream FSMs sample directly in their `clk` domain.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz); must be >= 2.
- LONG_CYCLES, 100000000: debounced-high cycles before long_flag fires (1 s); must be >= 1.
- REPEAT_CYCLES, 20000000: period of repeat_flag after long press (200 ms); must be >= 1.
- CNT_W, 32: width of the debounce and hold counters; must hold max(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  input  1  system clock, 100 MHz, all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- btn  input  1  raw asynchronous button, active-high.
- level  output  1  debounced button state.
- flag  output  1  one-cycle pulse on accepted press (level 0->1).
- release_flag  output  1  one-cycle pulse on accepted release (level 1->0).
- long_flag  output  1  one-cycle pulse when held LONG_CYCLES.
- repeat_flag  output  1  one-cycle pulse every REPEAT_CYCLES after long_flag while still held.

Behaviour:
- Reset values:
  - Sync flops, level, all four flags: 0.
  - Debounce and hold counters: 0.
  - FSM: IDLE.
  - Reset is asynchronous, so all outputs are 0 immediately, including mid-hold. If btn is still high when rst deasserts, that is treated as a fresh press.
- Synchroniser:
  - 2-flop chain btn -> s1 -> btn_s.
  - btn_s is used only after the second flop.
  - No logic touches btn directly.
- Debounce counter:
  - Any cycle with btn_s == level: counter <= 0.
  - btn_s != level and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - btn_s != level and counter == DEBOUNCE_CYCLES-1: level <= ~level, counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes level.
- Latency:
  - btn first sampled high at edge N and held stable.
  - level and flag are high after edge N+1+DEBOUNCE_CYCLES.
  - Release has the same latency for release_flag.
- FSM states:
  - IDLE: level=0.
  - HELD: level=1, before long threshold.
  - REPEAT: long press reached.
- FSM transitions:
  - IDLE -> HELD on level rise; flag=1 for that cycle, hold counter cleared.
  - HELD: hold counter +1 per cycle. On reaching LONG_CYCLES-1: long_flag=1 next cycle, go to REPEAT, hold counter cleared.
  - REPEAT: hold counter +1 per cycle. On reaching REPEAT_CYCLES-1: repeat_flag=1 next cycle, counter cleared, stay in REPEAT. No limit on repeat count.
  - HELD or REPEAT -> IDLE on level fall; release_flag=1 for that cycle, hold counter cleared.
- Simultaneous events:
  - Level fall has priority. long_flag and repeat_flag are suppressed in the cycle release_flag asserts and afterwards.
  - At most one of flag, release_flag, long_flag, repeat_flag is high in any cycle.
- Flags are registered outputs, never combinational from btn_s.
- Counters saturate-free: they are cleared on every transition, so no wrap occurs within valid parameters.

Decomposition:
- Shared package/header holds:
  - FSM encodings: IDLE=2'd0, HELD=2'd1, REPEAT=2'd2.
  - Board constants: CLK_HZ=100000000 and the default DEBOUNCE/LONG/REPEAT values, reused by all button-driven blocks.
- Natural sub-module: sync_2ff (1-bit, async active-high reset to 0).
- The rest stays in a single module.

Test Plan:
- Bench parameters for all cases: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8.
- Clean press: btn 0->1 sampled at edge 10, held 10 cycles then released -> level and flag high after edge 15; flag exactly 1 cycle wide; release_flag 5 cycles after release sampled; no long_flag.
- Bounce rejection: btn toggles high 3 cycles / low 1 cycle repeatedly for 40 cycles, then low -> level stays 0; no flags.
- Long press with repeats: btn held 60 cycles -> flag at t0, long_flag at t0+20, repeat_flag at t0+28, t0+36 and every 8 cycles until release, then release_flag; no repeat after release.
- Release races long: level falls in the cycle the hold counter would hit 19 -> release_flag=1, long_flag stays 0; FSM returns to IDLE.
- Reset mid-hold: rst pulsed while in REPEAT with btn still high -> all outputs 0 immediately; after rst low, flag fires again 2+4 cycles later.
- Exclusivity: random btn for 10000 cycles -> never more than one flag high in a cycle; every flag rise is paired with a later release_flag.
